out_port_scheduler: RTL and testbench
=====================================

// Module: out_port_scheduler
// PURPOSE
//  Round-robin scheduler for one router output port. Shares the port among NUM_IN
//  input-buffer FIFOs. When the downstream buffer is not full, it:
//  - picks one requester with a packet available;
//  - pops that packet with a one-cycle read strobe;
//  - streams it as PKT_BYTES serial bytes on the send_data/payload byte interface.
//  Sits between the per-input FIFO stage and the next hop's input buffer.
// PARAMETERS
//  NUM_IN     4  number of requesting input buffers (2..8)
//  PKT_BYTES  4  bytes per pkt_t; byte 0 is sent first
//  CNT_W      16 width of the sent-packet counter
// PORTS
//  clock       in   1               rising-edge clock
//  reset       in   1               synchronous, active-high reset
//  req_avail   in   NUM_IN          per-input packet available (FIFO not empty, dest matches)
//  pkt_in      in   NUM_IN x pkt_t  per-input FIFO head; first-word-fall-through, valid when req_avail
//  read_data   out  NUM_IN          one-hot pop strobe to the granted FIFO
//  dest_full   in   1               downstream input buffer full; blocks new packet starts
//  send_data   out  1               byte valid; high for exactly PKT_BYTES consecutive cycles per packet
//  payload     out  8               serial byte, valid when send_data=1, else 8'h00
//  grant_id    out  $clog2(NUM_IN)  index of input being sent (held during SEND)
//  busy        out  1               1 while in SEND
//  pkt_count   out  CNT_W           packets fully sent since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: IDLE, SEND. Counter byte_cnt, 0..PKT_BYTES-1.
//  Reset: state=IDLE, rr_ptr=0, byte_cnt=0, pkt_reg=0, pkt_count=0.
//  Output values in reset: read_data=0, send_data=0, payload=0, grant_id=0, busy=0.
//  IDLE:
//  - If |req_avail && !dest_full, g = first set bit of req_avail, searching circularly from rr_ptr.
//  - Same cycle: read_data[g]=1 (combinational; only one bit ever set).
//  - At the clock edge: pkt_reg<=pkt_in[g], grant_id<=g, rr_ptr<=(g+1)%NUM_IN, byte_cnt<=0, state<=SEND.
//  - Otherwise remain in IDLE with read_data=0.
//  SEND:
//  - send_data=1, payload=pkt_reg[byte_cnt], byte_cnt increments each cycle.
//  - At byte_cnt==PKT_BYTES-1: state<=IDLE, pkt_count<=pkt_count+1 (wraps).
//  Latency: first byte appears 1 cycle after the grant cycle.
//  Throughput: PKT_BYTES+1 cycles per packet. The IDLE cycle is a mandatory send_data=0 gap,
//   which the downstream buffer uses to close the packet.
//  dest_full is sampled only in IDLE. A packet once started is never stalled or aborted.
//  req_avail/pkt_in changes during SEND are ignored. Only rr_ptr governs fairness.
//  Single requester: re-granted every PKT_BYTES+1 cycles. No requests: rr_ptr is unchanged.
//  Reset mid-SEND: the next cycle is IDLE with send_data=0. The partial packet is truncated
//   downstream; this is accepted as a reset-only condition.
//  grant_id and pkt_reg stay stable from the grant edge until the next grant.
// STRUCTURE
//  router_pkg holds the shared types and constants:
//  - pkt_t: logic [0:PKT_BYTES-1][7:0], identical to the input-buffer packet type;
//  - PKT_BYTES;
//  - state enum sched_state_t {IDLE, SEND}.
//  One sub-module, rr_arbiter: combinational priority search from rr_ptr.
//  - Inputs: req vector, ptr.
//  - Outputs: valid, idx, onehot.
//  The parent holds the FSM, the pkt_reg/byte serializer and the counters.
// TESTING
//  1. Reset held 3 cycles, then req_avail=0 -> read_data=0, send_data=0, pkt_count=0, and IDLE is held.
//  2. req_avail=4'b0001, pkt_in[0]=32'hA1B2C3D4, dest_full=0:
//     -> read_data=4'b0001 for 1 cycle;
//     -> payload A1,B2,C3,D4 on 4 consecutive send_data cycles;
//     -> pkt_count=1.
//  3. req_avail=4'b1111 held continuously -> grant order 0,1,2,3,0. send_data has exactly one low
//     cycle between packets. Every 5 cycles one read strobe.
//  4. dest_full=1 with req_avail=4'b0100 -> no read_data and send_data=0.
//     dest_full asserted mid-SEND -> all 4 bytes still sent.
//     Release dest_full -> grant 2 on that cycle.
//  5. Assert reset during byte 2 of a packet -> the next cycle has send_data=0, pkt_count=0, rr_ptr=0.
//     With req_avail=4'b1000, the next grant is 3.
//  6. Preload pkt_count near 2^CNT_W-1 (force, or CNT_W=2 build), send 2 packets -> pkt_count wraps to 0.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared packet type, byte count and scheduler states for the router output port
package router_pkg;

    localparam int PKT_BYTES = 4;

    // Byte 0 is the leftmost element so it is the first byte on the wire.
    typedef logic [0:PKT_BYTES-1][7:0] pkt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

endpackage

// File: rtl/out_port_scheduler_if.sv
// rtl/out_port_scheduler_if.sv - request/pop/byte-stream bundle between input FIFOs, scheduler and next hop
interface out_port_scheduler_if #(
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
);
    import router_pkg::*;

    localparam int IDX_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0] req_avail;
    pkt_t              pkt_in [NUM_IN];
    logic [NUM_IN-1:0] read_data;
    logic              dest_full;
    logic              send_data;
    logic [7:0]        payload;
    logic [IDX_W-1:0]  grant_id;
    logic              busy;
    logic [CNT_W-1:0]  pkt_count;

    modport master (
        input  req_avail, pkt_in, dest_full,
        output read_data, send_data, payload, grant_id, busy, pkt_count
    );

    modport slave (
        output req_avail, pkt_in, dest_full,
        input  read_data, send_data, payload, grant_id, busy, pkt_count
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational circular priority search starting at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx,
    output logic [N-1:0]         onehot
);
    localparam int IDX_W = $clog2(N);

    int w_j;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        w_j    = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!valid && req[w_j]) begin
                valid = 1'b1;
                idx   = w_j[IDX_W-1:0];
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/out_port_scheduler.sv
// rtl/out_port_scheduler.sv - round-robin output-port scheduler: grant, pop, then serialise one packet
module out_port_scheduler #(
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
) (
    input logic             clock,
    input logic             reset,
    out_port_scheduler_if.master bus
);
    import router_pkg::*;

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int BC_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    sched_state_t      r_state;
    sched_state_t      w_next_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [BC_W-1:0]   r_byte_cnt;
    pkt_t              r_pkt_reg;
    logic [CNT_W-1:0]  r_pkt_count;

    logic              w_valid;
    logic [IDX_W-1:0]  w_idx;
    logic [NUM_IN-1:0] w_onehot;
    logic              w_start;
    logic              w_last;

    rr_arbiter #(.N(NUM_IN)) u_arb (
        .req    (bus.req_avail),
        .ptr    (r_rr_ptr),
        .valid  (w_valid),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs are forced quiet while reset is asserted, even before the state register clears.
    always_comb begin
        w_next_state  = r_state;
        w_start       = 1'b0;
        w_last        = (r_byte_cnt == BC_W'(PKT_BYTES - 1));
        bus.read_data = '0;
        bus.send_data = 1'b0;
        bus.payload   = 8'h00;
        bus.busy      = 1'b0;
        bus.grant_id  = reset ? '0 : r_grant_id;
        bus.pkt_count = r_pkt_count;
        case (r_state)
            IDLE: begin
                if (w_valid && !bus.dest_full && !reset) begin
                    w_start       = 1'b1;
                    w_next_state  = SEND;
                    bus.read_data = w_onehot;
                end
            end
            SEND: begin
                if (!reset) begin
                    bus.send_data = 1'b1;
                    bus.payload   = r_pkt_reg[r_byte_cnt];
                    bus.busy      = 1'b1;
                end
                if (w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_byte_cnt  <= '0;
            r_pkt_reg   <= '0;
            r_pkt_count <= '0;
        end else if (w_start) begin
            r_pkt_reg  <= bus.pkt_in[w_idx];
            r_grant_id <= w_idx;
            r_rr_ptr   <= (w_idx == IDX_W'(NUM_IN - 1)) ? '0 : w_idx + IDX_W'(1);
            r_byte_cnt <= '0;
        end else if (r_state == SEND) begin
            if (w_last) begin
                r_byte_cnt  <= '0;
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end else begin
                r_byte_cnt <= r_byte_cnt + BC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_out_port_scheduler.sv
// tb/tb_out_port_scheduler.sv - self-checking bench for out_port_scheduler with grant/byte scoreboard
module tb_out_port_scheduler;
    import router_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    out_port_scheduler_if #(.NUM_IN(4), .CNT_W(16)) bus  ();
    out_port_scheduler_if #(.NUM_IN(4), .CNT_W(2))  bus2 ();

    out_port_scheduler #(.NUM_IN(4), .CNT_W(16)) dut  (.clock(clk), .reset(reset), .bus(bus));
    out_port_scheduler #(.NUM_IN(4), .CNT_W(2))  dut2 (.clock(clk), .reset(reset), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mon_g;
    int mon_last_g = 0;
    int rel_cyc;

    int         exp_grant [$];
    logic [7:0] exp_byte  [$];
    int         grant_cyc [$];

    typedef struct {
        int          src;
        logic [31:0] data;
        int          exp_count;
    } vec_t;
    vec_t vecs [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every strobe and byte the DUT produces must match the next expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.read_data != '0) begin
                if (exp_grant.size() == 0) begin
                    check("unexpected_read", 32'(bus.read_data), 32'h0);
                end else begin
                    mon_g = exp_grant.pop_front();
                    check("read_data", 32'(bus.read_data), 32'(1 << mon_g));
                    mon_last_g = mon_g;
                    grant_cyc.push_back(cyc);
                end
            end
            if (bus.send_data) begin
                check("grant_id", 32'(bus.grant_id), 32'(mon_last_g));
                if (exp_byte.size() == 0) begin
                    check("unexpected_byte", 32'(bus.payload), 32'hFFFF_FFFF);
                end else begin
                    check("payload", 32'(bus.payload), 32'(exp_byte.pop_front()));
                end
            end else begin
                check("payload_idle", 32'(bus.payload), 32'h0);
            end
        end
    end

    task automatic push_pkt(input int src, input logic [31:0] data);
        exp_grant.push_back(src);
        for (int b = 0; b < PKT_BYTES; b++) begin
            exp_byte.push_back(data[31-8*b -: 8]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'h0);
    endtask

    task automatic send_one(input int src, input logic [31:0] data);
        bus.pkt_in[src] = data;
        bus.req_avail   = 4'(1 << src);
        push_pkt(src, data);
        @(posedge clk); #1;
        bus.req_avail = '0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d3 [4];
        int n;

        // Reset held 3 cycles; a request during reset must not produce a strobe.
        reset          = 1'b1;
        bus.req_avail  = '0;
        bus.dest_full  = 1'b0;
        bus2.req_avail = '0;
        bus2.dest_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pkt_in[i]  = '0;
            bus2.pkt_in[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 bus.req_avail = 4'hF;
        @(negedge clk);
        check("rst_read_data", 32'(bus.read_data), 32'h0);
        check("rst_send_data", 32'(bus.send_data), 32'h0);
        @(posedge clk); #1;
        bus.req_avail = '0;
        reset = 1'b0;
        check("rst_pkt_count", 32'(bus.pkt_count), 32'h0);
        check("rst_grant_id", 32'(bus.grant_id), 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_hold_busy", 32'(bus.busy), 32'h0);
            check("idle_hold_send", 32'(bus.send_data), 32'h0);
        end

        // Single-requester table; the last entry leaves rr_ptr at 0.
        vecs[0] = '{src: 0, data: 32'hA1B2C3D4, exp_count: 1};
        vecs[1] = '{src: 2, data: 32'h1122_3344, exp_count: 2};
        vecs[2] = '{src: 1, data: 32'h5566_7788, exp_count: 3};
        vecs[3] = '{src: 3, data: 32'h99AA_BBCC, exp_count: 4};
        for (int i = 0; i < 4; i++) begin
            send_one(vecs[i].src, vecs[i].data);
            check("pkt_count", 32'(bus.pkt_count), 32'(vecs[i].exp_count));
            check("bytes_left", 32'(exp_byte.size()), 32'h0);
        end

        // All four requesting continuously: order 0,1,2,3,0 with a strobe every 5 cycles.
        d3[0] = 32'h0001_0203; d3[1] = 32'h1011_1213;
        d3[2] = 32'h2021_2223; d3[3] = 32'h3031_3233;
        for (int i = 0; i < 4; i++) bus.pkt_in[i] = d3[i];
        push_pkt(0, d3[0]); push_pkt(1, d3[1]); push_pkt(2, d3[2]);
        push_pkt(3, d3[3]); push_pkt(0, d3[0]);
        grant_cyc.delete();
        bus.req_avail = 4'hF;
        repeat (21) @(posedge clk);
        #1 bus.req_avail = '0;
        wait_idle();
        check("rr_grants", 32'(grant_cyc.size()), 32'd5);
        for (int i = 1; i < grant_cyc.size(); i++) begin
            check("rr_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd5);
        end
        check("rr_bytes_left", 32'(exp_byte.size()), 32'h0);
        check("rr_pkt_count", 32'(bus.pkt_count), 32'd9);

        // dest_full blocks a start but never a packet already in flight.
        @(posedge clk); #1;
        bus.dest_full = 1'b1;
        bus.pkt_in[2] = 32'hDEAD_BEEF;
        bus.req_avail = 4'b0100;
        repeat (4) begin
            @(negedge clk);
            check("df_read_data", 32'(bus.read_data), 32'h0);
            check("df_send_data", 32'(bus.send_data), 32'h0);
        end
        @(posedge clk); #1;
        grant_cyc.delete();
        push_pkt(2, 32'hDEAD_BEEF);
        rel_cyc = cyc;
        bus.dest_full = 1'b0;
        @(posedge clk); #1;
        bus.dest_full = 1'b1;
        bus.req_avail = '0;
        wait_idle();
        check("df_grant_cnt", 32'(grant_cyc.size()), 32'd1);
        if (grant_cyc.size() > 0) check("df_grant_on_release", 32'(grant_cyc[0]), 32'(rel_cyc));
        check("df_bytes_left", 32'(exp_byte.size()), 32'h0);
        check("df_pkt_count", 32'(bus.pkt_count), 32'd10);
        bus.dest_full = 1'b0;

        // Reset during byte 2 truncates the packet and clears rr_ptr (stale ptr would pick 3 of 1001).
        @(posedge clk); #1;
        bus.pkt_in[1] = 32'hCAFE_F00D;
        bus.req_avail = 4'b0010;
        push_pkt(1, 32'hCAFE_F00D);
        @(posedge clk); #1;
        bus.req_avail = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_send", 32'(bus.send_data), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_count", 32'(bus.pkt_count), 32'h0);
        check("mid_rst_grant_q", 32'(exp_grant.size()), 32'h0);
        exp_byte.delete();
        bus.pkt_in[0] = 32'h0BAD_F00D;
        bus.pkt_in[3] = 32'h7E57_0003;
        bus.req_avail = 4'b1001;
        push_pkt(0, 32'h0BAD_F00D);
        @(posedge clk); #1;
        bus.req_avail = '0;
        wait_idle();
        send_one(3, 32'h7E57_0003);
        check("post_rst_count", 32'(bus.pkt_count), 32'd2);
        check("post_rst_bytes_left", 32'(exp_byte.size()), 32'h0);

        // Narrow counter instance wraps 3 -> 0.
        @(posedge clk); #1;
        bus2.pkt_in[0] = 32'h1234_5678;
        bus2.req_avail = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!bus2.busy && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            while (bus2.busy && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("wrap_timeout", 32'(n < 20), 32'h1);
            check("wrap_count", 32'(bus2.pkt_count), 32'((k + 1) % 4));
        end
        bus2.req_avail = '0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
